// File: rtl/alu_arb_pkg.sv
// Shared types for the two-requester accumulator-ALU arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_arb_pkg;

  // Default cycle limit on one ownership burst (used only with the timeout build)
  localparam int MAX_BURST_DEF = 8;

  // Op codes understood by the shared accumulator ALU
  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_SHIFT = 2'b10,
    OP_XNOR  = 2'b11
  } alu_op_e;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CLR  = 2'b01,
    ST_OWN0 = 2'b10,
    ST_OWN1 = 2'b11
  } arb_state_e;

endpackage

// File: rtl/alu_arb_burst_timer.sv
// Counts consecutive ownership cycles and flags when a burst has used its budget.
// Latency: expired is combinational from the count; count advances each run cycle.
// Backpressure: none; count clears whenever run drops.
module alu_arb_burst_timer
  import alu_arb_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic clk,
  input  logic RESET,
  input  logic run,
  output logic expired
);

  localparam int CW = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);

  logic [CW-1:0] cnt;

  // cnt holds the number of ownership cycles already completed in this burst
  always_ff @(posedge clk) begin
    if (RESET || !run) begin
      cnt <= '0;
    end else if (!expired) begin
      cnt <= cnt + CW'(1);
    end
  end

  // The current cycle is the last allowed one once MAX_BURST-1 cycles are behind us
  assign expired = run && (cnt >= CW'(MAX_BURST - 1));

endmodule

// File: rtl/alu_arb_ctrl.sv
// Round-robin arbiter granting bursts of ops on a shared accumulator ALU; macro ALU_ARB_CTRL_TIMEOUT_EN caps burst length.
// Latency: CLR cycle before each burst, then 1 op/cycle, response 1 cycle after each accepted op.
// Backpressure: reqN_ready is high only for the owner in OWN states; non-owner waits until the burst ends.
module alu_arb_ctrl
  import alu_arb_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       req0_valid,
  input  logic [1:0] req0_op,
  input  logic [3:0] req0_a,
  input  logic       req0_lock,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [1:0] req1_op,
  input  logic [3:0] req1_a,
  input  logic       req1_lock,
  output logic       req1_ready,
  output logic [1:0] alu_inst,
  output logic [3:0] alu_a,
  output logic       alu_clr,
  input  logic [3:0] alu_out,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [3:0] rsp_data
);

  arb_state_e state, state_nxt;
  logic       rr, rr_nxt;
  logic       owner, owner_nxt;
  logic       rsp_vld_q;
  logic       rsp_id_q;

  logic       in_own;
  logic       own_valid;
  logic       own_lock;
  logic [1:0] own_op;
  logic [3:0] own_a;
  logic       handshake;
  logic       timeout_end;
  logic       burst_end;

  assign in_own    = (state == ST_OWN0) || (state == ST_OWN1);
  assign own_valid = owner ? req1_valid : req0_valid;
  assign own_lock  = owner ? req1_lock  : req0_lock;
  assign own_op    = owner ? req1_op    : req0_op;
  assign own_a     = owner ? req1_a     : req0_a;
  // The owner's ready is unconditional in OWN, so its valid alone completes the handshake
  assign handshake = in_own && own_valid && !RESET;

`ifdef ALU_ARB_CTRL_TIMEOUT_EN
  logic other_valid;
  logic expired;

  assign other_valid = owner ? req0_valid : req1_valid;

  alu_arb_burst_timer #(
    .MAX_BURST(MAX_BURST)
  ) u_burst_timer (
    .clk    (clk),
    .RESET  (RESET),
    .run    (in_own),
    .expired(expired)
  );

  // Preempt a locked burst only when someone is actually waiting
  assign timeout_end = in_own && expired && other_valid;
`else
  assign timeout_end = 1'b0;
`endif

  assign burst_end = (handshake && !own_lock) || timeout_end;

  // Next-state, grant and ALU drive; idle ALU drive is shift-by-zero so the accumulator holds
  always_comb begin
    state_nxt  = state;
    rr_nxt     = rr;
    owner_nxt  = owner;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    alu_clr    = 1'b0;
    alu_inst   = OP_SHIFT;
    alu_a      = 4'b0000;
    case (state)
      ST_IDLE: begin
        if (req0_valid || req1_valid) begin
          owner_nxt = (req0_valid && req1_valid) ? rr : req1_valid;
          state_nxt = ST_CLR;
        end
      end
      ST_CLR: begin
        alu_clr   = 1'b1;
        state_nxt = owner ? ST_OWN1 : ST_OWN0;
      end
      ST_OWN0, ST_OWN1: begin
        req0_ready = !owner;
        req1_ready = owner;
        if (handshake) begin
          alu_inst = own_op;
          alu_a    = own_a;
        end
        if (burst_end) begin
          state_nxt = ST_IDLE;
          rr_nxt    = !owner;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Reset overrides grants and holds the ALU cleared
    if (RESET) begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      alu_clr    = 1'b1;
      alu_inst   = OP_SHIFT;
      alu_a      = 4'b0000;
    end
  end

  // State, round-robin pointer, owner and response registers
  always_ff @(posedge clk) begin
    if (RESET) begin
      state     <= ST_IDLE;
      rr        <= 1'b0;
      owner     <= 1'b0;
      rsp_vld_q <= 1'b0;
      rsp_id_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      rr        <= rr_nxt;
      owner     <= owner_nxt;
      rsp_vld_q <= handshake;
      if (handshake) begin
        rsp_id_q <= owner;
      end
    end
  end

  // Response is masked during reset so an op accepted just before reset is dropped
  assign rsp_valid = rsp_vld_q && !RESET;
  assign rsp_id    = rsp_id_q && !RESET;
  assign rsp_data  = alu_out;

endmodule
